// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode encodings, instruction field positions, decoded control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_stage_pkg;

  // Opcode encodings, instr[31:28]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;
  localparam logic [3:0] OP_NEG  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_BRZ  = 4'h9;
  localparam logic [3:0] OP_JM   = 4'hA;
  localparam logic [3:0] OP_BRN  = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hE;
  localparam logic [3:0] OP_SVPC = 4'hF;

  // Instruction field bit positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 10;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Decoded control bundle
  typedef struct packed {
    logic regwrt;
    logic memrd;
    logic memwrt;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_opcode_decoder.sv
// Opcode to control decoder; undefined opcodes flag illegal with every control cleared.
// Latency: purely combinational.
// Backpressure: none (no state).
module decode_stage_opcode_decoder
  import decode_stage_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Map each opcode to its control bits; anything not listed is illegal
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_SVPC, OP_ADD, OP_INC, OP_NEG, OP_SUB: ctrl.regwrt = 1'b1;
      OP_LD: begin
        ctrl.regwrt = 1'b1;
        ctrl.memrd  = 1'b1;
      end
      OP_JM:  ctrl.memrd  = 1'b1;
      OP_ST:  ctrl.memwrt = 1'b1;
      OP_NOP, OP_J, OP_BRZ, OP_BRN: begin
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Two-slot decode stage: slot A reads the register file, slot B presents the registered bundle to execute.
// Latency: accepted at edge N, ex_valid after edge N+1 (plus LOADUSE_STALL bubbles on a load-use hazard).
// Backpressure: ex_* hold while ex_valid && !ex_ready; in_ready drops when A is occupied and cannot move.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int LOADUSE_STALL = 1,
  parameter int XLEN          = 32,
  parameter int RADDR_W       = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic [RADDR_W-1:0] out_rs,
  output logic [RADDR_W-1:0] out_rt,
  input  logic [XLEN-1:0]    in_rsval,
  input  logic [XLEN-1:0]    in_rtval,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [3:0]         ex_opcode,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]    ex_rsval,
  output logic [XLEN-1:0]    ex_rtval,
  output logic [XLEN-1:0]    ex_imm,
  output logic [XLEN-1:0]    ex_pc,
  output logic               ex_regwrt,
  output logic               ex_memrd,
  output logic               ex_memwrt,
  output logic               ex_illegal
);

  // The hazard edge itself empties B, which is the first bubble; the counter
  // holds only the extra bubbles beyond that one.
  localparam logic [1:0] STALL_LOAD = 2'(LOADUSE_STALL - 1);

  // Slot A (read slot)
  logic               a_valid_q, a_valid_d;
  logic [XLEN-1:0]    a_instr_q, a_instr_d;
  logic [XLEN-1:0]    a_pc_q, a_pc_d;

  // Slot B (output slot)
  logic               b_valid_q, b_valid_d;
  logic [3:0]         b_opcode_q, b_opcode_d;
  logic [RADDR_W-1:0] b_rd_q, b_rd_d;
  logic [XLEN-1:0]    b_rsval_q, b_rsval_d;
  logic [XLEN-1:0]    b_rtval_q, b_rtval_d;
  logic [XLEN-1:0]    b_imm_q, b_imm_d;
  logic [XLEN-1:0]    b_pc_q, b_pc_d;
  ctrl_t              b_ctrl_q, b_ctrl_d;

  // Load-use stall counter
  logic [1:0]         cnt_q, cnt_d;

  // Fields of the instruction in slot A
  logic [3:0]         a_opcode;
  logic [RADDR_W-1:0] a_rd, a_rs, a_rt;
  logic [15:0]        a_imm16;
  ctrl_t              a_ctrl;

  logic hazard, a_moves, accept;

  assign a_opcode = a_instr_q[OP_HI:OP_LO];
  assign a_rd     = a_instr_q[RD_HI:RD_LO];
  assign a_rs     = a_instr_q[RS_HI:RS_LO];
  assign a_rt     = a_instr_q[RT_HI:RT_LO];
  assign a_imm16  = a_instr_q[IMM_HI:IMM_LO];

  decode_stage_opcode_decoder u_opcode_decoder (
    .opcode (a_opcode),
    .ctrl   (a_ctrl)
  );

  // Handshake, interlock and register-file read address selection
  always_comb begin
    hazard   = b_valid_q && ex_ready && b_ctrl_q.memrd && a_valid_q &&
               ((b_rd_q == a_rs) || (b_rd_q == a_rt));
    a_moves  = a_valid_q && (cnt_q == 2'd0) && (!b_valid_q || ex_ready) && !hazard;
    in_ready = !rst && (!a_valid_q || a_moves);
    accept   = in_valid && in_ready;
    // The register file registers these, so the operands land the cycle after A loads
    out_rs   = accept ? in_instr[RS_HI:RS_LO] : a_rs;
    out_rt   = accept ? in_instr[RT_HI:RT_LO] : a_rt;
  end

  // Next state for both slots and the stall counter; flush overrides everything
  always_comb begin
    a_valid_d  = a_valid_q;
    a_instr_d  = a_instr_q;
    a_pc_d     = a_pc_q;
    b_valid_d  = b_valid_q;
    b_opcode_d = b_opcode_q;
    b_rd_d     = b_rd_q;
    b_rsval_d  = b_rsval_q;
    b_rtval_d  = b_rtval_q;
    b_imm_d    = b_imm_q;
    b_pc_d     = b_pc_q;
    b_ctrl_d   = b_ctrl_q;
    cnt_d      = cnt_q;

    if (a_moves) begin
      a_valid_d = 1'b0;
    end
    if (accept) begin
      a_valid_d = 1'b1;
      a_instr_d = in_instr;
      a_pc_d    = in_pc;
    end

    if (b_valid_q && ex_ready) begin
      b_valid_d = 1'b0;
    end
    if (a_moves) begin
      b_valid_d  = 1'b1;
      b_opcode_d = a_opcode;
      b_rd_d     = a_rd;
      b_rsval_d  = in_rsval;
      b_rtval_d  = in_rtval;
      b_imm_d    = {{(XLEN-16){a_imm16[15]}}, a_imm16};
      b_pc_d     = a_pc_q;
      b_ctrl_d   = a_ctrl;
    end

    if (hazard) begin
      cnt_d = STALL_LOAD;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end

    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
      cnt_d     = 2'd0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q  <= 1'b0;
      a_instr_q  <= '0;
      a_pc_q     <= '0;
      b_valid_q  <= 1'b0;
      b_opcode_q <= '0;
      b_rd_q     <= '0;
      b_rsval_q  <= '0;
      b_rtval_q  <= '0;
      b_imm_q    <= '0;
      b_pc_q     <= '0;
      b_ctrl_q   <= '0;
      cnt_q      <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_instr_q  <= a_instr_d;
      a_pc_q     <= a_pc_d;
      b_valid_q  <= b_valid_d;
      b_opcode_q <= b_opcode_d;
      b_rd_q     <= b_rd_d;
      b_rsval_q  <= b_rsval_d;
      b_rtval_q  <= b_rtval_d;
      b_imm_q    <= b_imm_d;
      b_pc_q     <= b_pc_d;
      b_ctrl_q   <= b_ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid   = b_valid_q;
  assign ex_opcode  = b_opcode_q;
  assign ex_rd      = b_rd_q;
  assign ex_rsval   = b_rsval_q;
  assign ex_rtval   = b_rtval_q;
  assign ex_imm     = b_imm_q;
  assign ex_pc      = b_pc_q;
  assign ex_regwrt  = b_ctrl_q.regwrt;
  assign ex_memrd   = b_ctrl_q.memrd;
  assign ex_memwrt  = b_ctrl_q.memwrt;
  assign ex_illegal = b_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: write-first register file model, directed stimulus, queued expected bundles.
// Latency: n/a.
// Backpressure: bench drives ex_ready directly.
module tb_decode_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  ctl;   // {regwrt, memrd, memwrt, illegal}
  } bund_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [5:0]  out_rs, out_rt;
  logic [31:0] rsval_q, rtval_q;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [5:0]  ex_rd;
  logic [31:0] ex_rsval, ex_rtval, ex_imm, ex_pc;
  logic        ex_regwrt, ex_memrd, ex_memwrt, ex_illegal;

  logic        wb_en = 1'b0;
  logic [5:0]  wb_addr = '0;
  logic [31:0] wb_dat = '0;
  logic [31:0] rf [64];

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bund_t exp_q[$];
  int    out_cyc[$];

  decode_stage #(.LOADUSE_STALL(1), .XLEN(32), .RADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .in_rsval   (rsval_q),
    .in_rtval   (rtval_q),
    .ex_ready   (ex_ready),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_rd      (ex_rd),
    .ex_rsval   (ex_rsval),
    .ex_rtval   (ex_rtval),
    .ex_imm     (ex_imm),
    .ex_pc      (ex_pc),
    .ex_regwrt  (ex_regwrt),
    .ex_memrd   (ex_memrd),
    .ex_memwrt  (ex_memwrt),
    .ex_illegal (ex_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: registered read addresses, write-first on a same-edge write
  always @(posedge clk) begin
    if (wb_en) rf[wb_addr] <= wb_dat;
    rsval_q <= (wb_en && wb_addr == out_rs) ? wb_dat : rf[out_rs];
    rtval_q <= (wb_en && wb_addr == out_rt) ? wb_dat : rf[out_rt];
  end

  // Monitor: every handed-off bundle must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      bund_t got;
      bund_t exp;
      got = '{ex_opcode, ex_rd, ex_rsval, ex_rtval, ex_imm, ex_pc,
              {ex_regwrt, ex_memrd, ex_memwrt, ex_illegal}};
      n_checks++;
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_bundle: got pc=%h op=%h rd=%0d, required none", ex_pc, ex_opcode, ex_rd);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL bundle: got op=%h rd=%0d rs=%h rt=%h imm=%h pc=%h ctl=%b, required op=%h rd=%0d rs=%h rt=%h imm=%h pc=%h ctl=%b",
                   got.op, got.rd, got.rsv, got.rtv, got.imm, got.pc, got.ctl,
                   exp.op, exp.rd, exp.rsv, exp.rtv, exp.imm, exp.pc, exp.ctl);
        end
      end
    end
  end

  function automatic logic [31:0] mkins(input logic [3:0] op, input logic [5:0] rd,
                                        input logic [5:0] rs, input logic [5:0] rt,
                                        input logic [9:0] lo);
    return {op, rd, rs, rt, lo};
  endfunction

  function automatic bund_t mkexp(input logic [3:0] op, input logic [5:0] rd,
                                  input logic [31:0] rsv, input logic [31:0] rtv,
                                  input logic [31:0] imm, input logic [31:0] pc,
                                  input logic [3:0] ctl);
    return '{op, rd, rsv, rtv, imm, pc, ctl};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_dat = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  // Present an instruction until accepted; returns 1ns after the accepting edge
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input bund_t exp);
    bit done;
    done = 1'b0;
    exp_q.push_back(exp);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("issue_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int gap;
    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_opcode", {28'd0, ex_opcode}, 32'd0);
    chk("rst_ex_rsval", ex_rsval, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_ctl", {28'd0, ex_regwrt, ex_memrd, ex_memwrt, ex_illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_rs", {26'd0, out_rs}, 32'd0);

    wr(6'd0, 32'h0);
    wr(6'd1, 32'h8);
    wr(6'd2, 32'h100);
    wr(6'd5, 32'h500);
    wr(6'd7, 32'h7);
    wr(6'd9, 32'h9);
    wr(6'd63, 32'hDEAD);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single ADD r3 = r1, r2 and its one-edge latency
    issue(mkins(4'h4, 6'd3, 6'd1, 6'd2, 10'd0), 32'h100,
          mkexp(4'h4, 6'd3, 32'h8, 32'h100, 32'h800, 32'h100, 4'b1000));
    chk("add_not_yet_valid", {31'd0, ex_valid}, 32'd0);
    @(posedge clk); #1;
    chk("add_valid_n1", {31'd0, ex_valid}, 32'd1);
    chk("add_regwrt", {31'd0, ex_regwrt}, 32'd1);
    drain();

    // Back-to-back mix: illegal with sign-extended imm, SVPC, ST, JM, BRZ
    issue(mkins(4'h1, 6'd4, 6'd7, 6'd63, 10'h3FF), 32'h104,
          mkexp(4'h1, 6'd4, 32'h7, 32'hDEAD, 32'hFFFFFFFF, 32'h104, 4'b0001));
    issue(mkins(4'hF, 6'd10, 6'd2, 6'd9, 10'd5), 32'h108,
          mkexp(4'hF, 6'd10, 32'h100, 32'h9, 32'h2405, 32'h108, 4'b1000));
    issue(mkins(4'h3, 6'd0, 6'd7, 6'd2, 10'd0), 32'h10C,
          mkexp(4'h3, 6'd0, 32'h7, 32'h100, 32'h800, 32'h10C, 4'b0010));
    issue(mkins(4'hA, 6'd11, 6'd9, 6'd9, 10'd0), 32'h110,
          mkexp(4'hA, 6'd11, 32'h9, 32'h9, 32'h2400, 32'h110, 4'b0100));
    issue(mkins(4'h9, 6'd0, 6'd5, 6'd7, 10'd0), 32'h114,
          mkexp(4'h9, 6'd0, 32'h500, 32'h7, 32'h1C00, 32'h114, 4'b0000));
    drain();

    // Load-use: LD r5 then ADD using r5 -> exactly one bubble
    out_cyc.delete();
    issue(mkins(4'hE, 6'd5, 6'd9, 6'd9, 10'd4), 32'h200,
          mkexp(4'hE, 6'd5, 32'h9, 32'h9, 32'h2404, 32'h200, 4'b1100));
    issue(mkins(4'h4, 6'd6, 6'd5, 6'd2, 10'd0), 32'h204,
          mkexp(4'h4, 6'd6, 32'h500, 32'h100, 32'h800, 32'h204, 4'b1000));
    drain();
    chk("loaduse_outputs", out_cyc.size(), 32'd2);
    gap = (out_cyc.size() == 2) ? (out_cyc[1] - out_cyc[0]) : -1;
    chk("loaduse_gap_cycles", gap, 32'd2);

    // Write-back on the same edge the dependent instruction is read
    wb_en = 1'b1; wb_addr = 6'd1; wb_dat = 32'h55;
    issue(mkins(4'h4, 6'd8, 6'd1, 6'd2, 10'd0), 32'h300,
          mkexp(4'h4, 6'd8, 32'h55, 32'h100, 32'h800, 32'h300, 4'b1000));
    wb_en = 1'b0;
    drain();

    // Back-pressure with both slots full; r1 rewritten while its reader waits in A
    ex_ready = 1'b0;
    issue(mkins(4'h4, 6'd12, 6'd2, 6'd5, 10'd0), 32'h400,
          mkexp(4'h4, 6'd12, 32'h100, 32'h500, 32'h1400, 32'h400, 4'b1000));
    issue(mkins(4'h7, 6'd13, 6'd1, 6'd9, 10'd0), 32'h404,
          mkexp(4'h7, 6'd13, 32'h66, 32'h9, 32'h2400, 32'h404, 4'b1000));
    in_valid = 1'b1; in_instr = mkins(4'h6, 6'd14, 6'd2, 6'd2, 10'd0); in_pc = 32'h408;
    wb_en = 1'b1; wb_addr = 6'd1; wb_dat = 32'h66;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("bp_ex_pc", ex_pc, 32'h400);
      chk("bp_ex_rsval", ex_rsval, 32'h100);
      @(posedge clk); #1;
      wb_en = 1'b0;
    end
    ex_ready = 1'b1;
    issue(mkins(4'h6, 6'd14, 6'd2, 6'd2, 10'd0), 32'h408,
          mkexp(4'h6, 6'd14, 32'h100, 32'h100, 32'h800, 32'h408, 4'b1000));
    drain();

    // Flush beats a simultaneous accept
    in_valid = 1'b1; in_instr = mkins(4'h4, 6'd3, 6'd1, 6'd2, 10'd0); in_pc = 32'h4F0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_acc_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("flush_acc_no_output", {31'd0, ex_valid}, 32'd0);

    // Flush with B stalled and A full, then unchanged latency
    ex_ready = 1'b0;
    issue(mkins(4'h4, 6'd15, 6'd2, 6'd2, 10'd0), 32'h500,
          mkexp(4'h4, 6'd15, 32'h100, 32'h100, 32'h800, 32'h500, 4'b1000));
    issue(mkins(4'h4, 6'd15, 6'd2, 6'd2, 10'd0), 32'h504,
          mkexp(4'h4, 6'd15, 32'h100, 32'h100, 32'h800, 32'h504, 4'b1000));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    ex_ready = 1'b1;
    issue(mkins(4'h5, 6'd16, 6'd9, 6'd9, 10'd0), 32'h600,
          mkexp(4'h5, 6'd16, 32'h9, 32'h9, 32'h2400, 32'h600, 4'b1000));
    chk("postflush_not_yet", {31'd0, ex_valid}, 32'd0);
    @(posedge clk); #1;
    chk("postflush_valid_n1", {31'd0, ex_valid}, 32'd1);
    chk("postflush_pc", ex_pc, 32'h600);
    drain();

    // Asynchronous reset in the middle of a stall
    ex_ready = 1'b0;
    issue(mkins(4'h4, 6'd3, 6'd1, 6'd2, 10'd0), 32'h700,
          mkexp(4'h4, 6'd3, 32'h66, 32'h100, 32'h800, 32'h700, 4'b1000));
    issue(mkins(4'h4, 6'd3, 6'd1, 6'd2, 10'd0), 32'h704,
          mkexp(4'h4, 6'd3, 32'h66, 32'h100, 32'h800, 32'h704, 4'b1000));
    #2 rst = 1'b1;
    #1;
    chk("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_ex_pc", ex_pc, 32'd0);
    chk("arst_ex_rsval", ex_rsval, 32'd0);
    chk("arst_ex_rd_op", {22'd0, ex_rd, ex_opcode}, 32'd0);
    chk("arst_ex_ctl", {28'd0, ex_regwrt, ex_memrd, ex_memwrt, ex_illegal}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_out_rs", {26'd0, out_rs}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ex_ready = 1'b1;
    issue(mkins(4'h4, 6'd3, 6'd1, 6'd2, 10'd0), 32'h800,
          mkexp(4'h4, 6'd3, 32'h66, 32'h100, 32'h800, 32'h800, 4'b1000));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
